// File: rtl/nearest_hit_collector_pkg.sv
// Shared types for the nearest-hit collector: word widths, "no hit" distance,
// per-box hit record and the collector state encoding.
package nearest_hit_collector_pkg;

    localparam int WIDTH = 16;

    localparam logic signed [WIDTH-1:0] MAX_16 = {1'b0, {(WIDTH-1){1'b1}}};

    localparam int NHC_MAX_BOXES = 64;
    localparam int CNT_W         = $clog2(NHC_MAX_BOXES + 1);

    typedef struct packed {
        logic                    hit;
        logic signed [WIDTH-1:0] tmin;
        logic [CNT_W-1:0]        idx;
    } HitRecord;

    typedef enum logic [1:0] {
        NHC_IDLE    = 2'd0,
        NHC_COLLECT = 2'd1,
        NHC_REPORT  = 2'd2
    } NhcState;

endpackage

// File: rtl/nearest_hit_collector_min_select.sv
// Combinational selector: keeps the current best record unless the incoming
// record is a hit with a strictly smaller signed tmin (first arrival wins ties).
module hit_min_select
    import nearest_hit_collector_pkg::*;
(
    input  HitRecord cur_best,
    input  HitRecord incoming,
    output HitRecord new_best
);

    logic take_s;

    // Pick the closer of the two records.
    always_comb begin
        take_s   = 1'b0;
        new_best = cur_best;
        if (incoming.hit && ($signed(incoming.tmin) < $signed(cur_best.tmin))) begin
            take_s = 1'b1;
        end else begin
            take_s = 1'b0;
        end
        if (take_s) begin
            new_best = incoming;
        end else begin
            new_best = cur_best;
        end
    end

endmodule

// File: rtl/nearest_hit_collector.sv
// Nearest-hit collector: gathers per-box slab-test results of one ray and reports
// the closest hit over valid/ready. Optional watchdog: define NHC_TIMEOUT_EN.
module nearest_hit_collector
    import nearest_hit_collector_pkg::*;
#(
    parameter int                      MAX_BOXES = NHC_MAX_BOXES,
    parameter logic signed [WIDTH-1:0] TMIN_INIT = MAX_16,
    parameter int                      TIMEOUT   = 1024
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ray_start,
    input  logic [CNT_W-1:0] box_count,
    input  logic             hit_valid,
    input  logic             hit,
    input  logic [WIDTH-1:0] hit_tmin,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             any_hit,
    output logic [WIDTH-1:0] nearest_tmin,
    output logic [CNT_W-1:0] nearest_idx,
    output logic             protocol_err,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] MAX_BOXES_C = CNT_W'(MAX_BOXES);
    localparam HitRecord         BEST_INIT_C = '{hit: 1'b0, tmin: TMIN_INIT, idx: {CNT_W{1'b0}}};

    NhcState          state_r;
    NhcState          state_nxt_s;
    logic [CNT_W-1:0] target_r;
    logic [CNT_W-1:0] rcv_cnt_r;
    logic [CNT_W-1:0] box_clamped_s;
    HitRecord         best_r;
    HitRecord         cand_s;
    HitRecord         new_best_s;
    logic             accept_start_s;
    logic             collect_hit_s;
    logic             last_s;
    logic             drop_s;
    logic             wd_fire_s;
    logic             protocol_err_r;
    logic             out_valid_r;
    logic             busy_r;

    assign box_clamped_s  = (box_count > MAX_BOXES_C) ? MAX_BOXES_C : box_count;
    assign accept_start_s = (state_r == NHC_IDLE) && ray_start;
    assign collect_hit_s  = (state_r == NHC_COLLECT) && hit_valid;
    assign last_s         = collect_hit_s && ((rcv_cnt_r + CNT_W'(1)) == target_r);
    assign drop_s         = hit_valid && (state_r != NHC_COLLECT);
    assign cand_s         = '{hit: hit, tmin: hit_tmin, idx: rcv_cnt_r};

    hit_min_select u_min_select (
        .cur_best (best_r),
        .incoming (cand_s),
        .new_best (new_best_s)
    );

`ifdef NHC_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt_r;
    logic            timeout_r;

    assign wd_fire_s = (state_r == NHC_COLLECT) && !hit_valid &&
                       (wd_cnt_r == WD_W'(TIMEOUT - 1));

    // Watchdog: counts idle COLLECT cycles, restarted by every arriving result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt_r <= {WD_W{1'b0}};
        end else if ((state_r != NHC_COLLECT) || hit_valid) begin
            wd_cnt_r <= {WD_W{1'b0}};
        end else begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
        end
    end

    // Timeout qualifier travels with the result until the next ray is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_r <= 1'b0;
        end else if (accept_start_s) begin
            timeout_r <= 1'b0;
        end else if (wd_fire_s) begin
            timeout_r <= 1'b1;
        end else begin
            timeout_r <= timeout_r;
        end
    end

    assign timeout = timeout_r;
`else
    logic unused_timeout_s;

    assign unused_timeout_s = (TIMEOUT > 0);
    assign wd_fire_s        = 1'b0;
    assign timeout          = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= NHC_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            NHC_IDLE: begin
                if (ray_start) begin
                    if (box_clamped_s == {CNT_W{1'b0}}) begin
                        state_nxt_s = NHC_REPORT;
                    end else begin
                        state_nxt_s = NHC_COLLECT;
                    end
                end else begin
                    state_nxt_s = NHC_IDLE;
                end
            end
            NHC_COLLECT: begin
                if (last_s || wd_fire_s) begin
                    state_nxt_s = NHC_REPORT;
                end else begin
                    state_nxt_s = NHC_COLLECT;
                end
            end
            NHC_REPORT: begin
                if (out_ready) begin
                    state_nxt_s = NHC_IDLE;
                end else begin
                    state_nxt_s = NHC_REPORT;
                end
            end
            default: begin
                state_nxt_s = NHC_IDLE;
            end
        endcase
    end

    // Per-ray datapath: target latch, arrival counter and running best record.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            target_r  <= {CNT_W{1'b0}};
            rcv_cnt_r <= {CNT_W{1'b0}};
            best_r    <= BEST_INIT_C;
        end else if (accept_start_s) begin
            target_r  <= box_clamped_s;
            rcv_cnt_r <= {CNT_W{1'b0}};
            best_r    <= BEST_INIT_C;
        end else if (collect_hit_s) begin
            target_r  <= target_r;
            rcv_cnt_r <= rcv_cnt_r + CNT_W'(1);
            best_r    <= new_best_s;
        end else begin
            target_r  <= target_r;
            rcv_cnt_r <= rcv_cnt_r;
            best_r    <= best_r;
        end
    end

    // Sticky flag for results that arrived while nobody was collecting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            protocol_err_r <= 1'b0;
        end else if (drop_s) begin
            protocol_err_r <= 1'b1;
        end else begin
            protocol_err_r <= protocol_err_r;
        end
    end

    // Status outputs registered from the next state so they align with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            out_valid_r <= (state_nxt_s == NHC_REPORT);
            busy_r      <= (state_nxt_s != NHC_IDLE);
        end
    end

    assign busy         = busy_r;
    assign out_valid    = out_valid_r;
    assign any_hit      = best_r.hit;
    assign nearest_tmin = best_r.tmin;
    assign nearest_idx  = best_r.idx;
    assign protocol_err = protocol_err_r;

endmodule

// File: tb/tb_nearest_hit_collector.sv
// Self-checking bench for nearest_hit_collector: directed scenarios plus random
// rays checked against a queue-based nearest-hit model.
module tb_nearest_hit_collector;
    import nearest_hit_collector_pkg::*;

`ifdef NHC_TIMEOUT_EN
    localparam int TB_TIMEOUT = 16;
`else
    localparam int TB_TIMEOUT = 1024;
`endif
    localparam logic [15:0] EXP_INIT = 16'h7FFF;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             ray_start = 1'b0;
    logic [CNT_W-1:0] box_count = '0;
    logic             hit_valid = 1'b0;
    logic             hit = 1'b0;
    logic [WIDTH-1:0] hit_tmin = '0;
    logic             busy;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             any_hit;
    logic [WIDTH-1:0] nearest_tmin;
    logic [CNT_W-1:0] nearest_idx;
    logic             protocol_err;
    logic             timeout;

    int total = 0;
    int bad   = 0;

    nearest_hit_collector #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ray_start    (ray_start),
        .box_count    (box_count),
        .hit_valid    (hit_valid),
        .hit          (hit),
        .hit_tmin     (hit_tmin),
        .busy         (busy),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .any_hit      (any_hit),
        .nearest_tmin (nearest_tmin),
        .nearest_idx  (nearest_idx),
        .protocol_err (protocol_err),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    // All stimulus tasks are entered and left at a falling edge.
    task automatic start_ray(input int n);
        ray_start = 1'b1;
        box_count = 7'(n);
        @(negedge clk);
        ray_start = 1'b0;
    endtask

    task automatic send(input logic h, input logic [15:0] t);
        hit_valid = 1'b1;
        hit       = h;
        hit_tmin  = t;
        @(negedge clk);
        hit_valid = 1'b0;
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_ov_drop got=%b want=0", tag, out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy_drop got=%b want=0", tag, busy); end
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_ov got=%b want=0", tag, out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy got=%b want=0", tag, busy); end
        total++; if (any_hit !== 1'b0) begin bad++; $display("FAIL %s_any got=%b want=0", tag, any_hit); end
        total++; if (nearest_tmin !== EXP_INIT) begin bad++; $display("FAIL %s_tmin got=%h want=%h", tag, nearest_tmin, EXP_INIT); end
        total++; if (nearest_idx !== 7'd0) begin bad++; $display("FAIL %s_idx got=%0d want=0", tag, nearest_idx); end
        total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL %s_perr got=%b want=0", tag, protocol_err); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL %s_timeout got=%b want=0", tag, timeout); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset("reset");
    endtask

    task automatic test_basic();
        start_ray(3);
        send(1'b1, 16'h0800);
        ray_start = 1'b1;
        box_count = 7'd1;
        send(1'b1, 16'h0400);
        ray_start = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_ov got=%b want=0", out_valid); end
        send(1'b0, 16'h0100);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_ov got=%b want=1", out_valid); end
        total++; if (any_hit !== 1'b1) begin bad++; $display("FAIL basic_any got=%b want=1", any_hit); end
        total++; if (nearest_tmin !== 16'h0400) begin bad++; $display("FAIL basic_tmin got=%h want=0400", nearest_tmin); end
        total++; if (nearest_idx !== 7'd1) begin bad++; $display("FAIL basic_idx got=%0d want=1", nearest_idx); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy); end
        total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL basic_perr got=%b want=0", protocol_err); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL basic_timeout got=%b want=0", timeout); end
        handshake("basic");
    endtask

    task automatic test_no_hit();
        start_ray(2);
        send(1'b0, 16'h0100);
        send(1'b0, 16'h0050);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL nohit_ov got=%b want=1", out_valid); end
        total++; if (any_hit !== 1'b0) begin bad++; $display("FAIL nohit_any got=%b want=0", any_hit); end
        total++; if (nearest_tmin !== EXP_INIT) begin bad++; $display("FAIL nohit_tmin got=%h want=%h", nearest_tmin, EXP_INIT); end
        total++; if (nearest_idx !== 7'd0) begin bad++; $display("FAIL nohit_idx got=%0d want=0", nearest_idx); end
        handshake("nohit");
    endtask

    task automatic test_zero_boxes();
        start_ray(0);
        for (int c = 0; c < 5; c++) begin
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL zero_ov c%0d got=%b want=1", c, out_valid); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL zero_busy c%0d got=%b want=1", c, busy); end
            total++; if (any_hit !== 1'b0) begin bad++; $display("FAIL zero_any c%0d got=%b want=0", c, any_hit); end
            total++; if (nearest_tmin !== EXP_INIT) begin bad++; $display("FAIL zero_tmin c%0d got=%h want=%h", c, nearest_tmin, EXP_INIT); end
            @(negedge clk);
        end
        handshake("zero");
    endtask

    task automatic test_tie_protocol();
        start_ray(2);
        send(1'b1, 16'h0200);
        send(1'b1, 16'h0200);
        total++; if (nearest_idx !== 7'd0) begin bad++; $display("FAIL tie_idx got=%0d want=0", nearest_idx); end
        total++; if (nearest_tmin !== 16'h0200) begin bad++; $display("FAIL tie_tmin got=%h want=0200", nearest_tmin); end
        send(1'b1, 16'h0001);
        total++; if (protocol_err !== 1'b1) begin bad++; $display("FAIL tie_perr got=%b want=1", protocol_err); end
        total++; if (nearest_tmin !== 16'h0200) begin bad++; $display("FAIL tie_tmin_hold got=%h want=0200", nearest_tmin); end
        total++; if (nearest_idx !== 7'd0) begin bad++; $display("FAIL tie_idx_hold got=%0d want=0", nearest_idx); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL tie_ov got=%b want=1", out_valid); end
        handshake("tie");
        total++; if (protocol_err !== 1'b1) begin bad++; $display("FAIL tie_perr_sticky got=%b want=1", protocol_err); end
    endtask

    task automatic test_reset_mid();
        start_ray(4);
        send(1'b1, 16'h0123);
        do_reset("reset_mid");
        start_ray(2);
        send(1'b1, 16'h0040);
        send(1'b1, 16'h0030);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rmid_ov got=%b want=1", out_valid); end
        total++; if (nearest_tmin !== 16'h0030) begin bad++; $display("FAIL rmid_tmin got=%h want=0030", nearest_tmin); end
        total++; if (nearest_idx !== 7'd1) begin bad++; $display("FAIL rmid_idx got=%0d want=1", nearest_idx); end
        handshake("rmid");
    endtask

    task automatic test_start_cycle_drop();
        ray_start = 1'b1;
        box_count = 7'd2;
        hit_valid = 1'b1;
        hit       = 1'b1;
        hit_tmin  = 16'h0001;
        @(negedge clk);
        ray_start = 1'b0;
        hit_valid = 1'b0;
        total++; if (protocol_err !== 1'b1) begin bad++; $display("FAIL sdrop_perr got=%b want=1", protocol_err); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL sdrop_busy got=%b want=1", busy); end
        send(1'b1, 16'h0500);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sdrop_early_ov got=%b want=0", out_valid); end
        send(1'b1, 16'h0600);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sdrop_ov got=%b want=1", out_valid); end
        total++; if (nearest_tmin !== 16'h0500) begin bad++; $display("FAIL sdrop_tmin got=%h want=0500", nearest_tmin); end
        total++; if (nearest_idx !== 7'd0) begin bad++; $display("FAIL sdrop_idx got=%0d want=0", nearest_idx); end
        handshake("sdrop");
        do_reset("sdrop_reset");
    endtask

    // Random ray against the model: nearest = first hit with the smallest tmin.
    task automatic play_ray(input int n, input int ready_delay, input string tag);
        int                 target;
        int                 gap;
        int                 exp_idx;
        logic               exp_any;
        logic signed [15:0] exp_tmin;
        logic               h;
        logic signed [15:0] t;
        logic               q_hit[$];
        logic signed [15:0] q_tmin[$];
        target = (n > 64) ? 64 : n;
        start_ray(n);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy got=%b want=1", tag, busy); end
        for (int i = 0; i < target; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_early_ov i%0d got=%b want=0", tag, i, out_valid); end
            h = 1'($urandom_range(0, 1));
            if (h) begin
                if ($urandom_range(0, 1) == 1) t = 16'($urandom_range(0, 7) * 512);
                else t = 16'($urandom_range(0, 32766));
            end else begin
                t = 16'($urandom);
            end
            q_hit.push_back(h);
            q_tmin.push_back(t);
            send(h, t);
        end
        exp_any  = 1'b0;
        exp_tmin = 16'sh7FFF;
        exp_idx  = 0;
        foreach (q_hit[i]) begin
            if (q_hit[i] && (q_tmin[i] < exp_tmin)) begin
                exp_any  = 1'b1;
                exp_tmin = q_tmin[i];
                exp_idx  = i;
            end
        end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL %s_ov n%0d got=%b want=1", tag, n, out_valid); end
        total++; if (any_hit !== exp_any) begin bad++; $display("FAIL %s_any got=%b want=%b", tag, any_hit, exp_any); end
        total++; if (nearest_tmin !== exp_tmin) begin bad++; $display("FAIL %s_tmin got=%h want=%h", tag, nearest_tmin, exp_tmin); end
        total++; if (nearest_idx !== 7'(exp_idx)) begin bad++; $display("FAIL %s_idx got=%0d want=%0d", tag, nearest_idx, exp_idx); end
        total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL %s_perr got=%b want=0", tag, protocol_err); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL %s_timeout got=%b want=0", tag, timeout); end
        repeat (ready_delay) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL %s_hold_ov got=%b want=1", tag, out_valid); end
            total++; if (nearest_tmin !== exp_tmin) begin bad++; $display("FAIL %s_hold_tmin got=%h want=%h", tag, nearest_tmin, exp_tmin); end
        end
        handshake(tag);
    endtask

    task automatic test_random();
        for (int r = 0; r < 20; r++) begin
            play_ray($urandom_range(0, 10), $urandom_range(0, 3), "rand");
        end
    endtask

    task automatic test_clamp();
        play_ray(70, 1, "clamp");
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 4; r++) begin
            play_ray($urandom_range(1, 4), 0, "b2b");
        end
    endtask

`ifdef NHC_TIMEOUT_EN
    task automatic test_timeout();
        int waited;
        start_ray(2);
        send(1'b1, 16'h0300);
        waited = 0;
        while ((out_valid !== 1'b1) && (waited < 40)) begin
            @(negedge clk);
            waited++;
        end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL to_ov got=%b want=1 after %0d cycles", out_valid, waited); end
        total++; if (waited != 16) begin bad++; $display("FAIL to_cycles got=%0d want=16", waited); end
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_flag got=%b want=1", timeout); end
        total++; if (any_hit !== 1'b1) begin bad++; $display("FAIL to_any got=%b want=1", any_hit); end
        total++; if (nearest_tmin !== 16'h0300) begin bad++; $display("FAIL to_tmin got=%h want=0300", nearest_tmin); end
        total++; if (nearest_idx !== 7'd0) begin bad++; $display("FAIL to_idx got=%0d want=0", nearest_idx); end
        handshake("to");
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_hold got=%b want=1", timeout); end
        start_ray(1);
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_clear got=%b want=0", timeout); end
        send(1'b1, 16'h0010);
        handshake("to_next");
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_no_hit();
        test_zero_boxes();
        test_tie_protocol();
        test_reset_mid();
        test_start_cycle_drop();
        test_random();
        test_clamp();
        test_back_to_back();
`ifdef NHC_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
